// File: rtl/accum_sequencer.sv
// Press-driven sequencer for the shared adder/accumulator datapath: one accumulate per button press.
// Optional ACC_SATURATE_EN makes the accumulator stick at all-ones after any carry.
module accum_sequencer #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic             Clk,
  input  logic             Reset_Clear,
  input  logic             Run_Accumulate,
  input  logic             Clear_Req,
  input  logic [WIDTH-1:0] op_in,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic [WIDTH:0]   acc_out,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_WRITE, ST_DONE} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   acc;
  logic             sync_p0, sync_p1, sync_p2;
  logic             press;

`ifdef ACC_SATURATE_EN
  function automatic logic [WIDTH:0] wb_value(input logic [WIDTH:0] acc_cur,
                                              input logic cout,
                                              input logic [WIDTH-1:0] sum);
    if (cout || acc_cur[WIDTH]) return '1;
    return {cout, sum};
  endfunction
`else
  function automatic logic [WIDTH:0] wb_value(input logic cout,
                                              input logic [WIDTH-1:0] sum);
    return {cout, sum};
  endfunction
`endif

  // Falling edge of the synchronised button; sync_p2 holds its previous value.
  assign press = sync_p2 & ~sync_p1;

  assign add_a   = opnd_q;
  assign add_b   = acc[WIDTH-1:0];
  assign add_cin = 1'b0;
  assign acc_out = acc;

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      sync_p2    <= 1'b1;
      state      <= ST_IDLE;
      settle_cnt <= '0;
      opnd_q     <= '0;
      acc        <= '0;
      ovf        <= 1'b0;
      op_count   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sync_p0 <= Run_Accumulate;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
      done    <= 1'b0;
      if (Clear_Req) begin
        // Clear abandons any in-flight operation and swallows a coincident press.
        state      <= ST_IDLE;
        settle_cnt <= '0;
        opnd_q     <= '0;
        acc        <= '0;
        ovf        <= 1'b0;
        op_count   <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (press) begin
              opnd_q     <= op_in;
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_SETTLE;
              busy       <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == 4'd0) state <= ST_WRITE;
            else settle_cnt <= settle_cnt - 4'd1;
          end
          ST_WRITE: begin
`ifdef ACC_SATURATE_EN
            acc <= wb_value(acc, add_cout, add_s);
`else
            acc <= wb_value(add_cout, add_s);
`endif
            if (add_cout) ovf <= 1'b1;
            op_count <= op_count + 8'd1;
            done     <= 1'b1;
            state    <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Controller that sequences the shared 16-bit adder and 17-bit accumulator of the lab 3 adder datapath. It turns each press of the active-low Run_Accumulate button into exactly one accumulate operation. It drives the adder operands, waits a configurable number of settle cycles for slow adders such as the ripple adder, and writes the result back. It also tracks overflow and operation count, and replaces the one-shot control and router muxing at the top level.

## Interface
- WIDTH, 16, operand and adder width; accumulator is WIDTH+1 bits
- SETTLE, 2, cycles the adder inputs are held stable before the sum is captured; legal range 1..15
- Clk  in  1  system clock, all state on rising edge
- Reset_Clear  in  1  asynchronous, active-low reset; clears every register
- Run_Accumulate  in  1  raw active-low push button; one operation per press
- Clear_Req  in  1  synchronous active-high accumulator clear
- op_in  in  WIDTH  operand (zero-extended switches), sampled on press
- add_a  out  WIDTH  adder operand A (captured operand)
- add_b  out  WIDTH  adder operand B (acc[WIDTH-1:0])
- add_cin  out  1  constant 0
- add_s  in  WIDTH  adder sum
- add_cout  in  1  adder carry out
- acc_out  out  WIDTH+1  accumulator contents, bit WIDTH = carry of last add
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after writeback
- ovf  out  1  sticky, set when any add produced carry out
- op_count  out  8  number of completed accumulates, wraps

## Operation
- Run_Accumulate passes through a 2-flop synchronizer; both flops reset to 1 (released). A press is a 1->0 transition at the synchronizer output.
- FSM states: IDLE, SETTLE, WRITE, DONE.
  - IDLE: on a press, capture op_in into opnd_q, load settle counter with SETTLE-1, and go to SETTLE.
  - SETTLE: add_a = opnd_q and add_b = acc[WIDTH-1:0] are held constant. The counter decrements; at 0 the FSM goes to WRITE.
  - WRITE: acc <= {add_cout, add_s}; if add_cout, then ovf <= 1; op_count <= op_count+1. Next state is DONE.
  - DONE: done=1, then IDLE.
- add_a and add_b are driven from registers in every state; in IDLE they show opnd_q and the current acc.
- Presses while busy=1 are dropped, not queued. Holding the button produces no further operations.
- Clear_Req=1 in any state:
  - acc, ovf, op_count and opnd_q go to 0.
  - FSM goes to IDLE; the in-flight operation is abandoned and no done pulse is issued.
- Clear_Req and a press in the same cycle: Clear_Req wins and the press is discarded.
- Reset values: acc_out=0, busy=0, done=0, ovf=0, op_count=0, add_a=0, add_b=0, add_cin=0, FSM=IDLE.
- Reset deasserted mid-operation: identical to power-up; no partial writeback.

## Timing
- Pin to press detect: 2-3 cycles (synchronizer).
- With press detected in IDLE at cycle T:
  - SETTLE spans T+1 .. T+SETTLE.
  - WRITE is at T+SETTLE+1; the new acc_out is visible from T+SETTLE+2.
  - done=1 at T+SETTLE+2; IDLE at T+SETTLE+3.
- busy rises at T+1 and falls at T+SETTLE+3. The earliest next accepted press is at T+SETTLE+3.
- The adder is purely combinational and must settle within SETTLE clock periods.
- op_count wraps 255 -> 0 without affecting ovf.

## Configuration
- ACC_SATURATE_EN defined:
  - In WRITE, if add_cout=1, or acc[WIDTH] is already 1, acc <= {1'b1, all ones}.
  - The accumulator sticks at 0x1FFFF until Clear_Req or reset. ovf still sets.
- ACC_SATURATE_EN undefined: plain wrap-around as in WRITE above. The next add uses acc[WIDTH-1:0] only, so the previous carry is discarded and acc[WIDTH] reflects only the latest add.

## Test plan
- Reset, then press once with op_in=0x0012, SETTLE=2 -> acc_out=0x00012, op_count=1, ovf=0, done pulse exactly 1 cycle at T+4.
- acc=0x0FFF0, press with op_in=0x0020 -> acc_out=0x10010, ovf=1. With ACC_SATURATE_EN, acc_out=0x1FFFF and a further press with 0x0001 leaves it at 0x1FFFF.
- Hold Run_Accumulate low for 50 cycles, then press twice while busy -> exactly one accumulate and op_count +1.
- Assert Clear_Req during SETTLE -> acc_out=0, op_count=0, ovf=0, no done pulse, busy=0 the next cycle.
- Assert Clear_Req and a press edge in the same cycle -> acc_out=0 and FSM stays IDLE.
- 256 presses of op_in=0x0000 -> op_count wraps to 0, acc_out=0, ovf=0. Assert Reset_Clear mid-SETTLE -> all outputs at reset values immediately.
